// File: rtl/s_wb_sched.sv
// s_wb_sched: S-register writeback scheduler using a delay-indexed shift of result slots
module s_wb_sched #(
  parameter int NSREG = 8,
  parameter int MAXD  = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_issue,
  input  logic                     i_dest_en,
  input  logic [$clog2(NSREG)-1:0] i_dest,
  input  logic [3:0]               i_delay,
  input  logic [4:0]               i_src,
  output logic                     o_accept,
  output logic                     o_illegal,
  output logic                     o_s_wr_en,
  output logic [$clog2(NSREG)-1:0] o_s_wr_addr,
  output logic [4:0]               o_s_wr_src,
  output logic [NSREG-1:0]         o_s_busy,
  output logic                     o_idle
);
  localparam int AW = $clog2(NSREG);
  logic [MAXD:1]   v;
  logic [AW-1:0]   addr [1:MAXD];
  logic [4:0]      src  [1:MAXD];
  logic [NSREG-1:0] busy;
  logic [MAXD+1:0] v_ext;
  logic            slot_conf;
  logic            fire;
  // s[d+1] shifts into s[d] this cycle, so a valid s[d+1] blocks writing s[d]
  assign v_ext       = {1'b0, v, 1'b0};
  assign slot_conf   = v_ext[5'(i_delay) + 5'd1];
  assign o_illegal   = i_issue && i_dest_en && i_delay == 4'd0;
  assign fire        = i_issue && i_dest_en && i_delay != 4'd0 && !slot_conf && !busy[i_dest];
  assign o_accept    = !i_issue || !i_dest_en || i_delay == 4'd0 || fire;
  assign o_s_wr_en   = v[1];
  assign o_s_wr_addr = v[1] ? addr[1] : '0;
  assign o_s_wr_src  = v[1] ? src[1] : '0;
  assign o_s_busy    = busy;
  assign o_idle      = ~|v;
  always_ff @(posedge clk) begin
    if (rst) begin
      v    <= '0;
      busy <= '0;
    end else begin
      v    <= {1'b0, v[MAXD:2]};
      busy <= (busy & ~(v[1] ? NSREG'(1) << addr[1] : '0)) | (fire ? NSREG'(1) << i_dest : '0);
      if (fire) v[i_delay] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    for (int k = 1; k < MAXD; k++) begin
      addr[k] <= addr[k+1];
      src[k]  <= src[k+1];
    end
    if (fire) begin
      addr[i_delay] <= i_dest;
      src[i_delay]  <= i_src;
    end
  end
endmodule

// File: tb/tb_s_wb_sched.sv
// tb_s_wb_sched: directed vector table plus random traffic against a calendar-based reference model
module tb_s_wb_sched;
  logic       clk = 1'b0;
  logic       rst, i_issue, i_dest_en;
  logic [2:0] i_dest;
  logic [3:0] i_delay;
  logic [4:0] i_src;
  logic       o_accept, o_illegal, o_s_wr_en, o_idle;
  logic [2:0] o_s_wr_addr;
  logic [4:0] o_s_wr_src;
  logic [7:0] o_s_busy;

  s_wb_sched dut (
    .clk(clk), .rst(rst), .i_issue(i_issue), .i_dest_en(i_dest_en), .i_dest(i_dest),
    .i_delay(i_delay), .i_src(i_src), .o_accept(o_accept), .o_illegal(o_illegal),
    .o_s_wr_en(o_s_wr_en), .o_s_wr_addr(o_s_wr_addr), .o_s_wr_src(o_s_wr_src),
    .o_s_busy(o_s_busy), .o_idle(o_idle)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int now = 0;
  bit live = 0;

  // Calendar of future writebacks keyed by absolute cycle number (mod 32)
  logic       cal_v [32];
  logic [2:0] cal_a [32];
  logic [4:0] cal_s [32];

  typedef struct {
    int rep;
    logic r, iss, den;
    logic [2:0] dest;
    logic [3:0] dly;
    logic [4:0] src;
    logic acc, ill, wr;
    logic [2:0] addr;
    logic [7:0] busy;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, now);
    end
  endtask

  function automatic logic [7:0] m_busy();
    logic [7:0] b = '0;
    for (int j = 0; j < 32; j++) if (cal_v[j]) b[cal_a[j]] = 1'b1;
    return b;
  endfunction

  function automatic logic m_any();
    for (int j = 0; j < 32; j++) if (cal_v[j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_acc();
    if (!i_issue || !i_dest_en || i_delay == 0) return 1'b1;
    return !cal_v[(now + int'(i_delay)) % 32] && !m_busy()[i_dest];
  endfunction

  task automatic drive(input logic r, iss, den, input logic [2:0] d, input logic [3:0] dl, input logic [4:0] s);
    rst = r; i_issue = iss; i_dest_en = den; i_dest = d; i_delay = dl; i_src = s;
  endtask

  task automatic check_model();
    int c = now % 32;
    if (!live) return;
    if (!rst) begin
      chk("m_accept", 32'(o_accept), 32'(m_acc()));
      chk("m_illegal", 32'(o_illegal), 32'(i_issue && i_dest_en && i_delay == 0));
    end
    chk("m_wr_en", 32'(o_s_wr_en), 32'(cal_v[c]));
    chk("m_wr_addr", 32'(o_s_wr_addr), cal_v[c] ? 32'(cal_a[c]) : 32'd0);
    chk("m_wr_src", 32'(o_s_wr_src), cal_v[c] ? 32'(cal_s[c]) : 32'd0);
    chk("m_busy", 32'(o_s_busy), 32'(m_busy()));
    chk("m_idle", 32'(o_idle), 32'(!m_any()));
  endtask

  task automatic advance();
    logic take = live && m_acc() && i_issue && i_dest_en && i_delay != 0;
    @(posedge clk);
    if (rst) begin
      for (int j = 0; j < 32; j++) cal_v[j] = 1'b0;
      live = 1;
    end else begin
      cal_v[now % 32] = 1'b0;
      if (take) begin
        cal_v[(now + int'(i_delay)) % 32] = 1'b1;
        cal_a[(now + int'(i_delay)) % 32] = i_dest;
        cal_s[(now + int'(i_delay)) % 32] = i_src;
      end
    end
    now++;
    #1;
  endtask

  task automatic add(input int rep, input logic r, iss, den, input logic [2:0] d, input logic [3:0] dl,
                     input logic [4:0] s, input logic acc, ill, wr, input logic [2:0] a, input logic [7:0] b);
    vec_t t;
    t.rep = rep; t.r = r; t.iss = iss; t.den = den; t.dest = d; t.dly = dl; t.src = s;
    t.acc = acc; t.ill = ill; t.wr = wr; t.addr = a; t.busy = b;
    tbl.push_back(t);
  endtask

  task automatic idle(input int rep, input logic wr, input logic [2:0] a, input logic [7:0] b);
    add(rep, 0, 0, 0, 0, 0, 0, 1, 0, wr, a, b);
  endtask

  initial begin
    for (int j = 0; j < 32; j++) cal_v[j] = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    // reset
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    // slot collision then re-present
    add(1, 0, 1, 1, 1, 5, 5'h01, 1, 0, 0, 0, 8'h00);
    add(1, 0, 1, 1, 2, 4, 5'h02, 0, 0, 0, 0, 8'h02);
    add(1, 0, 1, 1, 2, 4, 5'h02, 1, 0, 0, 0, 8'h02);
    idle(2, 0, 0, 8'h06);
    idle(1, 1, 1, 8'h06);
    idle(1, 1, 2, 8'h04);
    idle(1, 0, 0, 8'h00);
    // WAW with same-cycle clear stall
    add(1, 0, 1, 1, 6, 2, 5'h03, 1, 0, 0, 0, 8'h00);
    add(1, 0, 1, 1, 6, 1, 5'h04, 0, 0, 0, 0, 8'h40);
    add(1, 0, 1, 1, 6, 1, 5'h04, 0, 0, 1, 6, 8'h40);
    add(1, 0, 1, 1, 6, 1, 5'h04, 1, 0, 0, 0, 8'h00);
    idle(1, 1, 6, 8'h40);
    idle(1, 0, 0, 8'h00);
    // illegal delay 0 and no-dest
    add(1, 0, 1, 1, 3, 0, 5'h05, 1, 1, 0, 0, 8'h00);
    add(1, 0, 1, 0, 3, 3, 5'h06, 1, 0, 0, 0, 8'h00);
    idle(1, 0, 0, 8'h00);
    // reset mid-flight, coinciding issue dropped
    add(1, 0, 1, 1, 0, 7, 5'h07, 1, 0, 0, 0, 8'h00);
    add(1, 0, 1, 1, 1, 7, 5'h08, 1, 0, 0, 0, 8'h01);
    add(1, 0, 1, 1, 2, 7, 5'h09, 1, 0, 0, 0, 8'h03);
    idle(1, 0, 0, 8'h07);
    add(1, 1, 1, 1, 3, 1, 5'h0A, 0, 0, 0, 0, 8'h00);
    idle(6, 0, 0, 8'h00);
    // single issue, latency exactly d
    add(1, 0, 1, 1, 3, 4, 5'h0A, 1, 0, 0, 0, 8'h00);
    idle(3, 0, 0, 8'h08);
    idle(1, 1, 3, 8'h08);
    idle(1, 0, 0, 8'h00);
    // out-of-order completion
    add(1, 0, 1, 1, 0, 14, 5'h0B, 1, 0, 0, 0, 8'h00);
    add(1, 0, 1, 1, 1, 1, 5'h0C, 1, 0, 0, 0, 8'h01);
    idle(1, 1, 1, 8'h03);
    idle(11, 0, 0, 8'h01);
    idle(1, 1, 0, 8'h01);
    idle(1, 0, 0, 8'h00);
    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      for (int n = 0; n < tbl[i].rep; n++) begin
        drive(tbl[i].r, tbl[i].iss, tbl[i].den, tbl[i].dest, tbl[i].dly, tbl[i].src);
        @(negedge clk);
        if (!tbl[i].r && live) begin
          chk($sformatf("v%0d_accept", i), 32'(o_accept), 32'(tbl[i].acc));
          chk($sformatf("v%0d_illegal", i), 32'(o_illegal), 32'(tbl[i].ill));
          chk($sformatf("v%0d_wr_en", i), 32'(o_s_wr_en), 32'(tbl[i].wr));
          chk($sformatf("v%0d_wr_addr", i), 32'(o_s_wr_addr), 32'(tbl[i].addr));
          chk($sformatf("v%0d_busy", i), 32'(o_s_busy), 32'(tbl[i].busy));
        end
        check_model();
        advance();
      end
    end
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8,
            3'($urandom), 4'($urandom), 5'($urandom));
      @(negedge clk);
      check_model();
      advance();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
